// File: rtl/vga_layer_sched.sv
// vga_layer_sched: per-pixel overlay layer scheduler with frame-synchronous config commit.
// Define LAYER_BLEND_EN to average a blending winner with the next layer below it (or BG_COLOR).
module vga_layer_sched #(
    parameter int                 N_LAYER  = 4,
    parameter int                 COLOR_W  = 16,
    parameter logic [COLOR_W-1:0] BG_COLOR = 16'h0000
) (
    input  logic               vga_clk,
    input  logic               sys_rst,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               vsync,
    input  logic               cfg_wr_en,
    input  logic [4:0]         cfg_addr,
    input  logic [15:0]        cfg_wr_data,
    input  logic               cfg_commit,
    output logic               cfg_ready,
    output logic               commit_done,
    output logic [COLOR_W-1:0] pix_data,
    output logic [N_LAYER-1:0] layer_hit
);

    typedef struct packed {
        logic [9:0]         x_start;
        logic [9:0]         y_start;
        logic [9:0]         x_end;
        logic [9:0]         y_end;
        logic [COLOR_W-1:0] color;
        logic               blend;
        logic               enable;
    } layer_t;

    typedef enum logic {IDLE, PEND} state_t;

    layer_t               shadow_q [N_LAYER];
    layer_t               shadow_d [N_LAYER];
    layer_t               active_q [N_LAYER];
    layer_t               active_d [N_LAYER];
    state_t               state_q, state_d;
    logic                 vsync_q;
    logic                 commit_done_q, commit_done_d;
    logic [COLOR_W-1:0]   pix_data_q, pix_data_d;
    logic [N_LAYER-1:0]   layer_hit_q, layer_hit_d;
    logic                 frame_start;

    assign frame_start = vsync & ~vsync_q;
    assign commit_done = commit_done_q;
    assign pix_data    = pix_data_q;
    assign layer_hit   = layer_hit_q;

`ifdef LAYER_BLEND_EN
    // Per-channel RGB565 average, truncating.
    function automatic logic [15:0] avg565(input logic [15:0] a, input logic [15:0] b);
        logic [5:0] r;
        logic [6:0] g;
        logic [5:0] bl;
        r  = {1'b0, a[15:11]} + {1'b0, b[15:11]};
        g  = {1'b0, a[10:5]}  + {1'b0, b[10:5]};
        bl = {1'b0, a[4:0]}   + {1'b0, b[4:0]};
        return {r[5:1], g[6:1], bl[5:1]};
    endfunction
`endif

    // Commit FSM and shadow/active register updates.
    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no path can infer a latch.
        state_d       = state_q;
        commit_done_d = 1'b0;
        cfg_ready     = (state_q == IDLE);
        shadow_d      = shadow_q;
        active_d      = active_q;

        if (cfg_wr_en && cfg_ready) begin
            for (int i = 0; i < N_LAYER; i++) begin
                if (cfg_addr[4:3] == 2'(i)) begin
                    case (cfg_addr[2:0])
                        3'd0:    shadow_d[i].x_start = cfg_wr_data[9:0];
                        3'd1:    shadow_d[i].y_start = cfg_wr_data[9:0];
                        3'd2:    shadow_d[i].x_end   = cfg_wr_data[9:0];
                        3'd3:    shadow_d[i].y_end   = cfg_wr_data[9:0];
                        3'd4:    shadow_d[i].color   = cfg_wr_data[COLOR_W-1:0];
                        3'd5: begin
                            shadow_d[i].enable = cfg_wr_data[0];
                            shadow_d[i].blend  = cfg_wr_data[1];
                        end
                        default: ;
                    endcase
                end
            end
        end

        case (state_q)
            IDLE: if (cfg_commit) state_d = PEND;
            PEND: begin
                if (frame_start) begin
                    active_d      = shadow_q;
                    commit_done_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel path: priority search over active layers, registered once.
    logic               valid;
    logic               hit;
    logic               win_found;
    logic [N_LAYER-1:0] win_hot;
    logic [COLOR_W-1:0] win_color;
`ifdef LAYER_BLEND_EN
    logic               win_blend;
    logic               under_found;
    logic [COLOR_W-1:0] under_color;
`endif

    always_comb begin
        valid     = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);
        hit       = 1'b0;
        win_found = 1'b0;
        win_hot   = '0;
        win_color = BG_COLOR;
`ifdef LAYER_BLEND_EN
        win_blend   = 1'b0;
        under_found = 1'b0;
        under_color = BG_COLOR;
`endif
        // NOTE: blocking assignments so each iteration sees whether an earlier layer already won.
        for (int i = 0; i < N_LAYER; i++) begin
            hit = active_q[i].enable &&
                  (pix_x >= active_q[i].x_start) && (pix_x < active_q[i].x_end) &&
                  (pix_y >= active_q[i].y_start) && (pix_y < active_q[i].y_end);
            if (hit && !win_found) begin
                win_found  = 1'b1;
                win_hot[i] = 1'b1;
                win_color  = active_q[i].color;
`ifdef LAYER_BLEND_EN
                win_blend  = active_q[i].blend;
            end else if (hit && !under_found) begin
                under_found = 1'b1;
                under_color = active_q[i].color;
`endif
            end
        end

        pix_data_d  = '0;
        layer_hit_d = '0;
        if (valid) begin
            pix_data_d = BG_COLOR;
            if (win_found) begin
                pix_data_d  = win_color;
                layer_hit_d = win_hot;
`ifdef LAYER_BLEND_EN
                if (win_blend) pix_data_d = avg565(win_color, under_color);
`endif
            end
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            // NOTE: the layer files are small flop arrays that must come up disabled, so unlike RAMs they are reset.
            for (int i = 0; i < N_LAYER; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            state_q       <= IDLE;
            vsync_q       <= 1'b0;
            commit_done_q <= 1'b0;
            pix_data_q    <= '0;
            layer_hit_q   <= '0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            state_q       <= state_d;
            vsync_q       <= vsync;
            commit_done_q <= commit_done_d;
            pix_data_q    <= pix_data_d;
            layer_hit_q   <= layer_hit_d;
        end
    end

endmodule
